ntt_poly_sched: RTL and testbench
=================================

Name: ntt_poly_sched

Overview:
- Parametrised polynomial-stream scheduler that replaces the hard-wired single-engine top level.
- Accepts whole polynomials over a valid/ready stream, each tagged with a mode (NTT, INTT or PWM) and an ID.
- Routes each polynomial's beats to the matching transform engine and re-tags the engine outputs into one output stream, with ID and last-beat marking.
- Drains in-flight work before any mode switch, so engine outputs never collide; overlapping polynomials of the same mode are tracked through a tag FIFO.

Parameters:
DATA_WIDTH, 12, coefficient width (matches `DATA_WIDTH)
POLY_N, 256, coefficients per polynomial
LANES, 2, coefficients per beat; POLY_N % LANES == 0
ID_W, 4, polynomial ID width
TAG_DEPTH, 4, max polynomials in flight for the active mode (power of 2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
s_valid  in  1  input beat valid
s_ready  out  1  input beat accepted when s_valid&s_ready
s_mode  in  2  0=NTT 1=INTT 2=PWM 3=reserved; sampled on first beat of polynomial
s_id  in  ID_W  polynomial ID; sampled on first beat
s_data_a  in  LANES*DATA_WIDTH  operand A lanes (lane 0 in LSBs)
s_data_b  in  LANES*DATA_WIDTH  operand B lanes (PWM only, else ignored)
ntt_in_en / intt_in_en / pwm_in_en  out  1  engine input strobe
ntt_in / intt_in  out  LANES*DATA_WIDTH  engine data
pwm_in  out  2*LANES*DATA_WIDTH  {B,A}
ntt_out_en / intt_out_en / pwm_out_en  in  1  engine output strobe
ntt_out / intt_out / pwm_out  in  LANES*DATA_WIDTH  engine result
m_valid  out  1  output beat (no backpressure)
m_data  out  LANES*DATA_WIDTH  result lanes
m_mode  out  2  mode of m_data
m_id  out  ID_W  ID of m_data polynomial
m_last  out  1  final beat of polynomial
busy  out  1  state!=IDLE or in-flight!=0
err  out  3  sticky {unexpected_out, collision, bad_mode}

Behaviour:
- BEATS = POLY_N/LANES. Input beat counter in_cnt, 0..BEATS-1; wraps to 0 on last accepted beat.
- Reset: all outputs 0, state=IDLE, counters 0, tag FIFO empty, err=0. Async assert; deassert synchronously.
- FSM states: IDLE, STREAM, DRAIN, DROP.
  - IDLE: s_ready=1. Accepted first beat enters STREAM and sets act_mode=s_mode; mode 3 enters DROP.
  - STREAM, in_cnt!=0: s_ready=1 (mid-polynomial).
  - STREAM, in_cnt==0: s_ready = (s_mode==act_mode) && !tag_full.
    - s_valid with a different mode -> DRAIN, s_ready=0.
    - Mode 3 is also a different mode -> DRAIN, then DROP.
  - DRAIN: s_ready=0 until in-flight==0, then IDLE. The next beat is accepted no earlier than 1 cycle after the last m_last.
  - DROP: beats are accepted and discarded, err[0] sets. After BEATS beats -> IDLE. No tag push, no engine strobe.
- Tag FIFO:
  - Push {id} on the first accepted beat of a polynomial in STREAM.
  - Pop on the output last beat.
  - tag_full blocks polynomial start only, never mid-polynomial.
- Engine drive:
  - Registered, latency 1 after the handshake.
  - Only the act_mode engine strobes; the other strobes are 0 and their data is held.
  - Gaps in s_valid mid-polynomial give gaps in in_en; engines tolerate gaps by contract.
- Output path:
  - Registered, latency 1 from engine out_en.
  - Output beat counter out_cnt; m_last when out_cnt==BEATS-1.
  - m_id = FIFO head; m_mode = act_mode of the polynomial.
- Errors:
  - out_en from a non-active engine: err[2]; the beat is ignored.
  - Two out_en in the same cycle: err[1]; the beat is ignored.
  - out_en with tag FIFO empty: err[2]; the beat is ignored.
- in-flight = FIFO occupancy. The tag is pushed at polynomial start, so an in-flight count of 0 means no started polynomial remains.
- Simultaneous push and pop: occupancy is unchanged.

Decomposition:
- ntt_sched_pkg:
  - mode_t enum {MODE_NTT, MODE_INTT, MODE_PWM, MODE_RSVD}.
  - state_t enum {IDLE, STREAM, DRAIN, DROP}.
  - Err bit index constants.
  - Function beats(POLY_N, LANES).
- Sub-module ntt_tag_fifo: synchronous FIFO, parameters ID_W and TAG_DEPTH; push/pop/full/empty/count; async rst.

Test Plan:
- Single NTT polynomial, ID 5, 128 beats (POLY_N=256, LANES=2), model latency 40:
  - ntt_in_en follows each handshake by 1 cycle.
  - 128 m_valid beats with m_id=5, m_mode=0; m_last only on beat 128; busy falls after it.
- Four back-to-back NTT polynomials, IDs 1..4:
  - A fifth start is blocked (s_ready=0 at in_cnt==0) until ID 1's m_last.
  - Output IDs come out in order 1,2,3,4.
- NTT (ID 7) then INTT (ID 8) offered immediately:
  - s_ready=0 from the INTT first beat until 1 cycle after NTT m_last.
  - Then intt_in_en fires and outputs have m_mode=1, m_id=8.
- s_mode=3 polynomial:
  - 128 beats are consumed with no engine strobes and no m_valid; err=3'b001.
  - A following PWM polynomial processes normally.
- Spurious intt_out_en during NTT streaming -> err[2]=1 and no m_valid for that beat; both ntt_out_en and pwm_out_en high together -> err[1]=1.
- rst asserted at NTT beat 60:
  - All outputs go 0 immediately; FIFO empties; err clears.
  - A new polynomial after release starts at in_cnt=0.

Source files
------------

// File: rtl/ntt_sched_pkg.sv
// Shared types and constants for the polynomial-stream scheduler.
// Modes, FSM states, error bit positions and the beats-per-polynomial helper.
package ntt_sched_pkg;

  typedef enum logic [1:0] {
    MODE_NTT  = 2'd0,
    MODE_INTT = 2'd1,
    MODE_PWM  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DROP   = 2'd3
  } state_t;

  localparam int ERR_BAD_MODE   = 0;
  localparam int ERR_COLLISION  = 1;
  localparam int ERR_UNEXPECTED = 2;

  function automatic int beats(input int poly_n, input int lanes);
    return poly_n / lanes;
  endfunction

endpackage

// File: rtl/ntt_tag_fifo.sv
// Tag FIFO holding the IDs of polynomials started but not yet fully emitted.
// Push at polynomial start, pop on the output last beat; count is the in-flight depth.
module ntt_tag_fifo #(
  parameter int ID_W      = 4,
  parameter int TAG_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [ID_W-1:0]              push_id,
  input  logic                         pop,
  output logic [ID_W-1:0]              head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(TAG_DEPTH):0]   count
);

  localparam int AW = $clog2(TAG_DEPTH);

  logic [ID_W-1:0] mem [TAG_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (AW+1)'(TAG_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

  // Pointers wrap naturally because TAG_DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ntt_poly_sched.sv
// Polynomial-stream scheduler: routes whole polynomials to the NTT/INTT/PWM engine
// of their mode and re-tags engine results into one output stream.
module ntt_poly_sched
  import ntt_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int POLY_N     = 256,
  parameter int LANES      = 2,
  parameter int ID_W       = 4,
  parameter int TAG_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [1:0]                    s_mode,
  input  logic [ID_W-1:0]               s_id,
  input  logic [LANES*DATA_WIDTH-1:0]   s_data_a,
  input  logic [LANES*DATA_WIDTH-1:0]   s_data_b,
  output logic                          ntt_in_en,
  output logic                          intt_in_en,
  output logic                          pwm_in_en,
  output logic [LANES*DATA_WIDTH-1:0]   ntt_in,
  output logic [LANES*DATA_WIDTH-1:0]   intt_in,
  output logic [2*LANES*DATA_WIDTH-1:0] pwm_in,
  input  logic                          ntt_out_en,
  input  logic                          intt_out_en,
  input  logic                          pwm_out_en,
  input  logic [LANES*DATA_WIDTH-1:0]   ntt_out,
  input  logic [LANES*DATA_WIDTH-1:0]   intt_out,
  input  logic [LANES*DATA_WIDTH-1:0]   pwm_out,
  output logic                          m_valid,
  output logic [LANES*DATA_WIDTH-1:0]   m_data,
  output logic [1:0]                    m_mode,
  output logic [ID_W-1:0]               m_id,
  output logic                          m_last,
  output logic                          busy,
  output logic [2:0]                    err
);

  localparam int LW    = LANES * DATA_WIDTH;
  localparam int BEATS = beats(POLY_N, LANES);
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  state_t                     state, state_nxt;
  mode_t                      act_mode, s_mode_e, eng_mode;
  logic [CW-1:0]              in_cnt, out_cnt;
  logic                       fire, stream_beat, drop_beat, push, pop;
  logic                       tag_full, tag_empty;
  logic [ID_W-1:0]            tag_head;
  logic [$clog2(TAG_DEPTH):0] tag_count;
  logic                       collide, any_en, act_en, out_ok, unexpected;
  logic [LW-1:0]              act_data;

  assign s_mode_e = mode_t'(s_mode);
  // The first beat out of IDLE steers by its own mode; act_mode is only loaded by that beat.
  assign eng_mode = (state == IDLE) ? s_mode_e : act_mode;

  // A beat transfers on a cycle where s_valid && s_ready; s_ready never depends on
  // anything but state, counters, FIFO fullness and the offered mode.
  assign fire        = s_valid && s_ready;
  assign stream_beat = fire && ((state == STREAM) || ((state == IDLE) && (s_mode_e != MODE_RSVD)));
  assign drop_beat   = fire && !stream_beat;
  assign push        = stream_beat && (in_cnt == '0);
  assign busy        = (state != IDLE) || (tag_count != '0);

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    case (state)
      IDLE: begin
        s_ready = 1'b1;
        if (s_valid) state_nxt = (s_mode_e == MODE_RSVD) ? DROP : STREAM;
      end
      STREAM: begin
        if (in_cnt != '0) begin
          s_ready = 1'b1;
        end else begin
          s_ready = (s_mode_e == act_mode) && !tag_full;
          if (s_valid && (s_mode_e != act_mode)) state_nxt = DRAIN;
          else if (!s_valid && tag_empty)        state_nxt = IDLE;
        end
      end
      DRAIN: begin
        if (tag_empty) state_nxt = IDLE;
      end
      DROP: begin
        s_ready = 1'b1;
        if (s_valid && (in_cnt == LAST)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) s_ready = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      act_mode   <= MODE_NTT;
      in_cnt     <= '0;
      ntt_in_en  <= 1'b0;
      intt_in_en <= 1'b0;
      pwm_in_en  <= 1'b0;
      ntt_in     <= '0;
      intt_in    <= '0;
      pwm_in     <= '0;
    end else begin
      state      <= state_nxt;
      ntt_in_en  <= 1'b0;
      intt_in_en <= 1'b0;
      pwm_in_en  <= 1'b0;
      if (fire) in_cnt <= (in_cnt == LAST) ? '0 : in_cnt + 1'b1;
      if ((state == IDLE) && fire && (s_mode_e != MODE_RSVD)) act_mode <= s_mode_e;
      if (stream_beat) begin
        case (eng_mode)
          MODE_NTT:  begin ntt_in_en  <= 1'b1; ntt_in  <= s_data_a; end
          MODE_INTT: begin intt_in_en <= 1'b1; intt_in <= s_data_a; end
          MODE_PWM:  begin pwm_in_en  <= 1'b1; pwm_in  <= {s_data_b, s_data_a}; end
          default:   ;
        endcase
      end
    end
  end

  always_comb begin
    act_en   = 1'b0;
    act_data = ntt_out;
    case (act_mode)
      MODE_NTT:  begin act_en = ntt_out_en;  act_data = ntt_out;  end
      MODE_INTT: begin act_en = intt_out_en; act_data = intt_out; end
      MODE_PWM:  begin act_en = pwm_out_en;  act_data = pwm_out;  end
      default:   ;
    endcase
  end

  assign collide    = (ntt_out_en && intt_out_en) || (ntt_out_en && pwm_out_en) ||
                      (intt_out_en && pwm_out_en);
  assign any_en     = ntt_out_en || intt_out_en || pwm_out_en;
  assign out_ok     = any_en && !collide && act_en && !tag_empty;
  assign unexpected = any_en && !collide && (!act_en || tag_empty);
  assign pop        = out_ok && (out_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_mode  <= '0;
      m_id    <= '0;
      m_last  <= 1'b0;
      out_cnt <= '0;
      err     <= '0;
    end else begin
      m_valid <= out_ok;
      m_last  <= pop;
      if (out_ok) begin
        m_data  <= act_data;
        m_mode  <= act_mode;
        m_id    <= tag_head;
        out_cnt <= (out_cnt == LAST) ? '0 : out_cnt + 1'b1;
      end
      if (drop_beat)  err[ERR_BAD_MODE]   <= 1'b1;
      if (collide)    err[ERR_COLLISION]  <= 1'b1;
      if (unexpected) err[ERR_UNEXPECTED] <= 1'b1;
    end
  end

  ntt_tag_fifo #(
    .ID_W      (ID_W),
    .TAG_DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .push_id (s_id),
    .pop     (pop),
    .head    (tag_head),
    .full    (tag_full),
    .empty   (tag_empty),
    .count   (tag_count)
  );

endmodule

// File: tb/tb_ntt_poly_sched.sv
// Directed bench for ntt_poly_sched with latency-configurable behavioural engines
// and an expected-output queue for the re-tagged result stream.
module tb_ntt_poly_sched;

  localparam int DATA_WIDTH = 12;
  localparam int POLY_N     = 256;
  localparam int LANES      = 2;
  localparam int ID_W       = 4;
  localparam int TAG_DEPTH  = 4;
  localparam int LW         = LANES * DATA_WIDTH;
  localparam int BEATS      = POLY_N / LANES;
  localparam int EW         = 2 + ID_W + 1 + LW;
  localparam int BOUND      = 2000;
  localparam logic [LW-1:0] KN = 24'h0F00F0;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic               s_valid, s_ready;
  logic [1:0]         s_mode;
  logic [ID_W-1:0]    s_id;
  logic [LW-1:0]      s_data_a, s_data_b;
  logic               ntt_in_en, intt_in_en, pwm_in_en;
  logic [LW-1:0]      ntt_in, intt_in;
  logic [2*LW-1:0]    pwm_in;
  logic               ntt_out_en, intt_out_en, pwm_out_en;
  logic [LW-1:0]      ntt_out, intt_out, pwm_out;
  logic               m_valid, m_last, busy;
  logic [LW-1:0]      m_data;
  logic [1:0]         m_mode;
  logic [ID_W-1:0]    m_id;
  logic [2:0]         err;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          lat = 40;
  bit          chk_on = 1'b0;
  logic [2:0]  hs_exp = 3'b000;
  int          last_cyc [16];
  logic [EW-1:0] exp_q [$];
  int          first_hs;

  logic inj_ntt = 1'b0, inj_intt = 1'b0, inj_pwm = 1'b0;
  logic ntt_en_m, intt_en_m, pwm_en_m;
  int            ntt_due [$], intt_due [$], pwm_due [$];
  logic [LW-1:0] ntt_dq [$], intt_dq [$], pwm_dq [$];

  ntt_poly_sched #(
    .DATA_WIDTH (DATA_WIDTH),
    .POLY_N     (POLY_N),
    .LANES      (LANES),
    .ID_W       (ID_W),
    .TAG_DEPTH  (TAG_DEPTH)
  ) dut (
    .clk (clk), .rst (rst),
    .s_valid (s_valid), .s_ready (s_ready), .s_mode (s_mode), .s_id (s_id),
    .s_data_a (s_data_a), .s_data_b (s_data_b),
    .ntt_in_en (ntt_in_en), .intt_in_en (intt_in_en), .pwm_in_en (pwm_in_en),
    .ntt_in (ntt_in), .intt_in (intt_in), .pwm_in (pwm_in),
    .ntt_out_en (ntt_out_en), .intt_out_en (intt_out_en), .pwm_out_en (pwm_out_en),
    .ntt_out (ntt_out), .intt_out (intt_out), .pwm_out (pwm_out),
    .m_valid (m_valid), .m_data (m_data), .m_mode (m_mode), .m_id (m_id),
    .m_last (m_last), .busy (busy), .err (err)
  );

  assign ntt_out_en  = ntt_en_m  | inj_ntt;
  assign intt_out_en = intt_en_m | inj_intt;
  assign pwm_out_en  = pwm_en_m  | inj_pwm;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [LW-1:0] model_out(input logic [1:0] mode, input logic [LW-1:0] a,
                                               input logic [LW-1:0] b);
    case (mode)
      2'd0:    return a ^ KN;
      2'd1:    return ~a;
      default: return a - b;
    endcase
  endfunction

  // behavioural engines: fixed latency, in-order
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ntt_due.delete();  ntt_dq.delete();
      intt_due.delete(); intt_dq.delete();
      pwm_due.delete();  pwm_dq.delete();
      ntt_en_m <= 1'b0; intt_en_m <= 1'b0; pwm_en_m <= 1'b0;
      ntt_out <= '0; intt_out <= '0; pwm_out <= '0;
    end else begin
      if (ntt_in_en)  begin ntt_due.push_back(cyc + lat);  ntt_dq.push_back(ntt_in ^ KN); end
      if (intt_in_en) begin intt_due.push_back(cyc + lat); intt_dq.push_back(~intt_in); end
      if (pwm_in_en)  begin
        pwm_due.push_back(cyc + lat);
        pwm_dq.push_back(pwm_in[LW-1:0] - pwm_in[2*LW-1:LW]);
      end
      ntt_en_m <= 1'b0; intt_en_m <= 1'b0; pwm_en_m <= 1'b0;
      if (ntt_due.size() > 0 && ntt_due[0] <= cyc) begin
        ntt_en_m <= 1'b1; ntt_out <= ntt_dq.pop_front(); void'(ntt_due.pop_front());
      end
      if (intt_due.size() > 0 && intt_due[0] <= cyc) begin
        intt_en_m <= 1'b1; intt_out <= intt_dq.pop_front(); void'(intt_due.pop_front());
      end
      if (pwm_due.size() > 0 && pwm_due[0] <= cyc) begin
        pwm_en_m <= 1'b1; pwm_out <= pwm_dq.pop_front(); void'(pwm_due.pop_front());
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // scoreboard + engine strobe monitor
  always @(negedge clk) begin
    if (!rst && chk_on) begin
      check("in_en", {ntt_in_en, intt_in_en, pwm_in_en}, hs_exp);
      hs_exp = 3'b000;
      if (m_valid) begin
        if (m_last) last_cyc[m_id] = cyc;
        if (exp_q.size() == 0) check("m_unexpected", m_valid, 1'b0);
        else                   check("m_beat", {m_mode, m_id, m_last, m_data}, exp_q.pop_front());
      end
    end
  end

  // driver: offers nb beats of one polynomial, pushes expectations per handshake
  task automatic send_poly(input logic [1:0] mode, input logic [ID_W-1:0] id, input bit drop,
                           input bit exp_block, input bit gaps, input int nb, output int hs0);
    logic [LW-1:0] a, b;
    int t;
    hs0 = 0;
    for (int i = 0; i < nb; i++) begin
      a = {4'(id), 8'(i * 3), 12'(i)};
      b = {12'(i ^ 32'h5A5), 12'(id * 7)};
      s_valid = 1'b1; s_mode = mode; s_id = id; s_data_a = a; s_data_b = b;
      #1;
      if (i == 0 && exp_block) check("start_blocked", s_ready, 1'b0);
      t = 0;
      while (!s_ready && t < BOUND) begin @(negedge clk); #1; t++; end
      if (!s_ready) begin
        check("ready_timeout", s_ready, 1'b1);
        s_valid = 1'b0;
        return;
      end
      @(posedge clk);
      if (!drop) begin
        exp_q.push_back({mode, id, (i == BEATS - 1), model_out(mode, a, b)});
        hs_exp = (mode == 2'd0) ? 3'b100 : (mode == 2'd1) ? 3'b010 : 3'b001;
      end
      @(negedge clk);
      if (i == 0) hs0 = cyc;
      s_valid = 1'b0;
      if (gaps && (i % 16 == 5)) @(negedge clk);
    end
  endtask

  task automatic wait_drain(input string tag);
    int t = 0;
    while (exp_q.size() != 0 && t < 4000) begin @(negedge clk); t++; end
    check({tag, "_drain"}, exp_q.size(), 0);
    repeat (3) @(negedge clk);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    s_valid = 1'b0; s_mode = '0; s_id = '0; s_data_a = '0; s_data_b = '0;
    foreach (last_cyc[k]) last_cyc[k] = 0;
    repeat (3) @(negedge clk);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 3'b000);
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_in_en", {ntt_in_en, intt_in_en, pwm_in_en}, 3'b000);
    rst = 1'b0;
    chk_on = 1'b1;
    @(negedge clk);

    // single NTT polynomial
    lat = 40;
    send_poly(2'd0, 4'd5, 1'b0, 1'b0, 1'b0, BEATS, first_hs);
    wait_drain("t1");
    check("t1_err", err, 3'b000);

    // four back-to-back NTT polynomials fill the tag FIFO; a fifth start must wait
    lat = 450;
    for (int p = 1; p <= 4; p++) send_poly(2'd0, 4'(p), 1'b0, 1'b0, 1'b0, BEATS, first_hs);
    send_poly(2'd0, 4'd6, 1'b0, 1'b1, 1'b0, BEATS, first_hs);
    check("t2_after_id1_last", (last_cyc[1] != 0) && (first_hs > last_cyc[1]), 1'b1);
    wait_drain("t2");

    // NTT then INTT: mode switch drains first
    lat = 40;
    send_poly(2'd0, 4'd7, 1'b0, 1'b0, 1'b0, BEATS, first_hs);
    send_poly(2'd1, 4'd8, 1'b0, 1'b1, 1'b0, BEATS, first_hs);
    check("t3_gap_after_last", (last_cyc[7] != 0) && (first_hs >= last_cyc[7] + 2), 1'b1);
    wait_drain("t3");

    // reserved mode is swallowed, then PWM (with input gaps) runs normally
    send_poly(2'd3, 4'd2, 1'b1, 1'b0, 1'b0, BEATS, first_hs);
    repeat (5) @(negedge clk);
    check("t4_err_bad_mode", err, 3'b001);
    check("t4_busy", busy, 1'b0);
    send_poly(2'd2, 4'd10, 1'b0, 1'b0, 1'b1, BEATS, first_hs);
    wait_drain("t4");
    check("t4_err_hold", err, 3'b001);

    // spurious INTT output and an NTT/PWM collision while NTT streams
    fork
      send_poly(2'd0, 4'd11, 1'b0, 1'b0, 1'b0, BEATS, first_hs);
      begin
        repeat (10) @(negedge clk);
        inj_intt = 1'b1;
        @(negedge clk);
        inj_intt = 1'b0;
        check("t5_spur_m_valid", m_valid, 1'b0);
        check("t5_spur_err", err, 3'b101);
        repeat (5) @(negedge clk);
        inj_ntt = 1'b1; inj_pwm = 1'b1;
        @(negedge clk);
        inj_ntt = 1'b0; inj_pwm = 1'b0;
        check("t5_coll_m_valid", m_valid, 1'b0);
        check("t5_coll_err", err, 3'b111);
      end
    join
    wait_drain("t5");

    // reset in the middle of a polynomial
    send_poly(2'd0, 4'd12, 1'b0, 1'b0, 1'b0, 60, first_hs);
    rst = 1'b1;
    #1;
    check("t6_m_valid", m_valid, 1'b0);
    check("t6_m_last", m_last, 1'b0);
    check("t6_m_data", {m_data, m_id, m_mode}, '0);
    check("t6_busy", busy, 1'b0);
    check("t6_err", err, 3'b000);
    check("t6_s_ready", s_ready, 1'b0);
    check("t6_in_en", {ntt_in_en, intt_in_en, pwm_in_en}, 3'b000);
    exp_q.delete();
    repeat (2) @(negedge clk);
    hs_exp = 3'b000;
    rst = 1'b0;
    @(negedge clk);
    send_poly(2'd0, 4'd3, 1'b0, 1'b0, 1'b0, BEATS, first_hs);
    wait_drain("t6");
    check("t6_err_after", err, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit (compared=%0d)", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
